// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: run/pause/single-step sequencer for the 8-LED
// pattern display. Owns the step prescaler, the position counter, the
// bounce direction flag and the mode register. All outputs are registered,
// and Pattern is always recomputed from the next mode register and position.
module led_pattern_scheduler #(
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic       ClkIn,
    input  logic       ResetN,
    input  logic [1:0] Mode,
    input  logic       Dir,
    input  logic [1:0] Speed,
    input  logic       RunToggle,
    input  logic       StepReq,
    output logic [7:0] Pattern,
    output logic [2:0] Pos,
    output logic       Running,
    output logic       StepPulse
);

    // The prescaler must reach TICK_DIV*8-1 at the slowest speed.
    localparam int unsigned CNT_W = $clog2(TICK_DIV * 8);
    localparam int unsigned PER_W = CNT_W + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [2:0]         pos_q, pos_d;
    logic               up_q, up_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         pattern_q, pattern_d;
    logic               pulse_q, pulse_d;
    logic               running_q, running_d;
    logic               rt_prev_q, rt_prev_d;
    logic               sr_prev_q, sr_prev_d;

    logic               rt_edge_s;
    logic               sr_edge_s;
    logic               mode_chg_s;
    logic               terminal_s;
    logic               step_s;
    logic [PER_W-1:0]   period_s;
    logic [3:0]         next_s;

    // LED image for a given mode and position.
    function automatic logic [7:0] pattern_of(input logic [1:0] mode, input logic [2:0] pos);
        logic [7:0] pat;
        case (mode)
            2'd0, 2'd1: pat = 8'h01 << pos;
            2'd2:       pat = (8'h01 << pos) | (8'h80 >> pos);
            2'd3:       pat = (pos == 3'd0) ? 8'hFF : 8'h00;
            default:    pat = 8'h01;
        endcase
        return pat;
    endfunction

    // Next {up flag, position} for one step in the given mode.
    function automatic logic [3:0] next_of(input logic [1:0] mode, input logic dir,
                                           input logic up, input logic [2:0] pos);
        logic [3:0] nxt;
        case (mode)
            2'd0: nxt = {up, dir ? pos - 3'd1 : pos + 3'd1};
            2'd1: begin
                // Endpoints reverse direction so 7 and 0 are never repeated.
                if (up) begin
                    nxt = (pos == 3'd7) ? {1'b0, 3'd6} : {1'b1, pos + 3'd1};
                end else begin
                    nxt = (pos == 3'd0) ? {1'b1, 3'd1} : {1'b0, pos - 3'd1};
                end
            end
            2'd2:    nxt = {up, 1'b0, dir ? pos[1:0] - 2'd1 : pos[1:0] + 2'd1};
            2'd3:    nxt = {up, (pos == 3'd0) ? 3'd1 : 3'd0};
            default: nxt = {1'b1, 3'd0};
        endcase
        return nxt;
    endfunction

    // Edge detection, prescaler terminal and prioritised next-state selection.
    always_comb begin
        rt_edge_s  = RunToggle & ~rt_prev_q;
        sr_edge_s  = StepReq & ~sr_prev_q;
        mode_chg_s = (Mode != mode_q);
        period_s   = PER_W'(TICK_DIV) << Speed;
        // >= rather than == so that lowering Speed never waits for a wrap.
        terminal_s = (state_q == ST_RUN) && ({1'b0, cnt_q} >= (period_s - PER_W'(1)));
        step_s     = terminal_s | (sr_edge_s & (state_q == ST_PAUSED));
        next_s     = next_of(mode_q, Dir, up_q, pos_q);

        state_d   = state_q;
        mode_d    = mode_q;
        pos_d     = pos_q;
        up_d      = up_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        rt_prev_d = RunToggle;
        sr_prev_d = StepReq;

        if (mode_chg_s) begin
            // A mode change owns the cycle: any toggle or step is dropped.
            mode_d = Mode;
            pos_d  = 3'd0;
            up_d   = 1'b1;
            cnt_d  = '0;
        end else if (rt_edge_s) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            cnt_d   = '0;
        end else if (step_s) begin
            up_d    = next_s[3];
            pos_d   = next_s[2:0];
            cnt_d   = '0;
            pulse_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        pattern_d = pattern_of(mode_d, pos_d);
        running_d = (state_d == ST_RUN);
    end

    // State registers; previous-input flops reset high so held inputs do nothing.
    always_ff @(posedge ClkIn or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= ST_RUN;
            mode_q    <= 2'd0;
            pos_q     <= 3'd0;
            up_q      <= 1'b1;
            cnt_q     <= '0;
            pattern_q <= 8'h01;
            pulse_q   <= 1'b0;
            running_q <= 1'b1;
            rt_prev_q <= 1'b1;
            sr_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            pos_q     <= pos_d;
            up_q      <= up_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            rt_prev_q <= rt_prev_d;
            sr_prev_q <= sr_prev_d;
        end
    end

    assign Pattern   = pattern_q;
    assign Pos       = pos_q;
    assign Running   = running_q;
    assign StepPulse = pulse_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with TICK_DIV = 4.
module tb_led_pattern_scheduler;

    logic       ClkIn = 1'b0;
    logic       ResetN;
    logic [1:0] Mode;
    logic       Dir;
    logic [1:0] Speed;
    logic       RunToggle;
    logic       StepReq;
    logic [7:0] Pattern;
    logic [2:0] Pos;
    logic       Running;
    logic       StepPulse;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_pat_r;

    led_pattern_scheduler #(.TICK_DIV(4)) dut (
        .ClkIn     (ClkIn),
        .ResetN    (ResetN),
        .Mode      (Mode),
        .Dir       (Dir),
        .Speed     (Speed),
        .RunToggle (RunToggle),
        .StepReq   (StepReq),
        .Pattern   (Pattern),
        .Pos       (Pos),
        .Running   (Running),
        .StepPulse (StepPulse)
    );

    always #5 ClkIn = ~ClkIn;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Three quiet cycles, then a step on the fourth edge.
    task automatic expect_step(input logic [2:0] p, input logic [7:0] pat);
        repeat (3) begin
            @(negedge ClkIn);
            chk("hold_pulse", 32'(StepPulse), 32'd0);
            chk("hold_pat", 32'(Pattern), 32'(exp_pat_r));
        end
        @(negedge ClkIn);
        chk("step_pos", 32'(Pos), 32'(p));
        chk("step_pat", 32'(Pattern), 32'(pat));
        chk("step_pulse", 32'(StepPulse), 32'd1);
        exp_pat_r = pat;
    endtask

    // Mode change seen at the next edge: position 0, no pulse.
    task automatic expect_modechg(input logic [7:0] pat);
        @(negedge ClkIn);
        chk("mc_pos", 32'(Pos), 32'd0);
        chk("mc_pat", 32'(Pattern), 32'(pat));
        chk("mc_pulse", 32'(StepPulse), 32'd0);
        exp_pat_r = pat;
    endtask

    int bpos [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    logic [7:0] one8;

    initial begin
        one8      = 8'h01;
        ResetN    = 1'b0;
        Mode      = 2'd0;
        Dir       = 1'b0;
        Speed     = 2'd0;
        RunToggle = 1'b0;
        StepReq   = 1'b0;
        repeat (2) @(negedge ClkIn);
        chk("rst_pat", 32'(Pattern), 32'h01);
        chk("rst_pos", 32'(Pos), 32'd0);
        chk("rst_run", 32'(Running), 32'd1);
        chk("rst_pulse", 32'(StepPulse), 32'd0);
        ResetN    = 1'b1;
        exp_pat_r = 8'h01;

        // Mode 0 rotate up through a full wrap.
        for (int k = 1; k <= 8; k++) begin
            expect_step(3'(k % 8), one8 << (k % 8));
        end
        // Reverse direction.
        Dir = 1'b1;
        expect_step(3'd7, 8'h80);
        expect_step(3'd6, 8'h40);

        // Mode 1 bounce; Dir is ignored here.
        Mode = 2'd1;
        expect_modechg(8'h01);
        for (int k = 0; k < 16; k++) begin
            expect_step(3'(bpos[k]), one8 << bpos[k]);
        end

        // Mode 2 converge, both directions.
        Mode = 2'd2;
        Dir  = 1'b0;
        expect_modechg(8'h81);
        expect_step(3'd1, 8'h42);
        expect_step(3'd2, 8'h24);
        expect_step(3'd3, 8'h18);
        expect_step(3'd0, 8'h81);
        Dir = 1'b1;
        expect_step(3'd3, 8'h18);
        expect_step(3'd2, 8'h24);
        expect_step(3'd1, 8'h42);

        // Mode 3 blink.
        Mode = 2'd3;
        expect_modechg(8'hFF);
        expect_step(3'd1, 8'h00);
        expect_step(3'd0, 8'hFF);
        expect_step(3'd1, 8'h00);

        // Pause and hold for 100 cycles.
        RunToggle = 1'b1;
        @(negedge ClkIn);
        RunToggle = 1'b0;
        chk("pause_run", 32'(Running), 32'd0);
        chk("pause_pulse", 32'(StepPulse), 32'd0);
        for (int k = 0; k < 100; k++) begin
            @(negedge ClkIn);
            chk("frozen_pat", 32'(Pattern), 32'h00);
            chk("frozen_pulse", 32'(StepPulse), 32'd0);
        end

        // Three single steps while paused.
        for (int k = 0; k < 3; k++) begin
            StepReq = 1'b1;
            @(negedge ClkIn);
            StepReq = 1'b0;
            chk("ss_pulse", 32'(StepPulse), 32'd1);
            chk("ss_pat", 32'(Pattern), (k % 2 == 0) ? 32'hFF : 32'h00);
            chk("ss_pos", 32'(Pos), (k % 2 == 0) ? 32'd0 : 32'd1);
            @(negedge ClkIn);
            chk("ss_after", 32'(StepPulse), 32'd0);
            chk("ss_run", 32'(Running), 32'd0);
            @(negedge ClkIn);
        end
        exp_pat_r = 8'hFF;

        // Simultaneous toggle and step request: resume, no step.
        RunToggle = 1'b1;
        StepReq   = 1'b1;
        @(negedge ClkIn);
        RunToggle = 1'b0;
        StepReq   = 1'b0;
        chk("both_run", 32'(Running), 32'd1);
        chk("both_pulse", 32'(StepPulse), 32'd0);
        chk("both_pat", 32'(Pattern), 32'hFF);
        expect_step(3'd1, 8'h00);

        // Mode 0 up to position 5, then switch to mode 2 mid-period.
        Mode = 2'd0;
        Dir  = 1'b0;
        expect_modechg(8'h01);
        for (int k = 1; k <= 5; k++) begin
            expect_step(3'(k), one8 << k);
        end
        repeat (2) begin
            @(negedge ClkIn);
            chk("mid_pulse", 32'(StepPulse), 32'd0);
        end
        Mode = 2'd2;
        expect_modechg(8'h81);
        expect_step(3'd1, 8'h42);

        // Speed 3 (period 32), prescaler reaches 20, then drop to Speed 0.
        Speed = 2'd3;
        for (int k = 0; k < 20; k++) begin
            @(negedge ClkIn);
            chk("slow_pulse", 32'(StepPulse), 32'd0);
        end
        Speed = 2'd0;
        @(negedge ClkIn);
        chk("fast_pulse", 32'(StepPulse), 32'd1);
        chk("fast_pos", 32'(Pos), 32'd2);
        chk("fast_pat", 32'(Pattern), 32'h24);

        // Reset in the cycle of a scheduled step, RunToggle held through release.
        repeat (3) @(negedge ClkIn);
        RunToggle = 1'b1;
        Mode      = 2'd0;
        ResetN    = 1'b0;
        #1;
        chk("arst_pat", 32'(Pattern), 32'h01);
        chk("arst_pos", 32'(Pos), 32'd0);
        chk("arst_run", 32'(Running), 32'd1);
        chk("arst_pulse", 32'(StepPulse), 32'd0);
        @(negedge ClkIn);
        ResetN    = 1'b1;
        exp_pat_r = 8'h01;
        expect_step(3'd1, 8'h02);
        chk("held_toggle_run", 32'(Running), 32'd1);
        RunToggle = 1'b0;
        expect_step(3'd2, 8'h04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_scheduler.md
# led_pattern_scheduler

Sequencing controller for the 8-LED pattern display on the virtual board. It replaces the free-running 1 Hz pattern FSM with a run/pause/single-step scheduler. It owns the step-rate prescaler, the pattern position counter and the mode register, and drives L[7:0] directly. It sits between the debounced PB/S inputs and the LED outputs in the board top level.

## Interface
- TICK_DIV, default 2500000: base step period in ClkIn cycles (4 Hz at 10 MHz); legal range ≥ 2
- ClkIn  in  1  10 MHz system clock; all state on rising edge
- ResetN  in  1  asynchronous, active-low reset
- Mode  in  2  pattern select: 0 rotate, 1 bounce, 2 converge, 3 blink
- Dir  in  1  0 = position increments, 1 = decrements (modes 0 and 2 only)
- Speed  in  2  step period = TICK_DIV << Speed cycles
- RunToggle  in  1  synchronous, debounced level; rising edge toggles run/pause
- StepReq  in  1  synchronous, debounced level; rising edge = single step while paused
- Pattern  out  8  LED pattern, registered
- Pos  out  3  current position, registered
- Running  out  1  1 = RUN state
- StepPulse  out  1  one-cycle pulse marking each step

## Operation
- Control FSM: RUN, PAUSED. Rising edge of RunToggle toggles state; entering either state clears the prescaler.
- Edge detect: In & ~Prev, Prev registers reset to 1, so inputs held through reset cause no action.
- Prescaler counts only in RUN. Terminal condition is count ≥ (TICK_DIV << Speed) − 1, then step and clear. Width must hold TICK_DIV·8 − 1. The ≥ compare makes a Speed decrease take effect without a long wait.
- Step source: prescaler terminal in RUN, or StepReq edge in PAUSED. StepReq in RUN is ignored.
- Position rules per step:
  - Mode 0: Pos ± 1 mod 8, Pattern = 1 << Pos.
  - Mode 1: Pos bounces 0..7..0 without repeating the endpoints (…6,7,6…1,0,1…). Internal up flag reverses at 7 and 0. Pattern = 1 << Pos. Dir is ignored.
  - Mode 2: Pos ± 1 mod 4, Pattern = (1 << Pos) | (8'h80 >> Pos), giving 81,42,24,18.
  - Mode 3: Pos toggles 0/1. Pattern = FF when Pos = 0, 00 when Pos = 1.
- Mode register samples Mode every cycle. When Mode differs from the register:
  - register ← Mode, Pos ← 0, bounce flag ← up, prescaler ← 0;
  - any step in that same cycle is dropped;
  - StepPulse stays 0.
- Priorities, highest first: reset, mode change, RunToggle edge, step. A RunToggle edge in the same cycle as a StepReq edge toggles the state and drops the step.
- Dir and Speed are sampled live. A change alters only subsequent steps and never resets Pos.
- Invariant: Pattern == f(mode register, Pos) in every cycle after reset.

## Timing
- Reset values: state RUN, Pos 0, Pattern 8'h01, Running 1, StepPulse 0, mode register 0, bounce flag up, prescaler 0.
- Pos, Pattern and StepPulse update on the same clock edge. StepPulse is high for exactly the one cycle following that edge.
- RUN: from a cleared prescaler, the first step edge comes TICK_DIV << Speed cycles later. Steps are then periodic at that interval.
- PAUSED single step: StepReq high at sampling edge n → new Pos/Pattern and StepPulse visible after edge n (1-cycle latency).
- Mode change seen at edge n → Pattern = f(new mode, 0) after edge n. The next RUN step comes a full period later.
- Running changes after the edge that samples the RunToggle rise.
- ResetN low mid-step forces reset values immediately (asynchronous). Deassertion is synchronised by the board wrapper.

## Test plan
- Reset, TICK_DIV=4, Speed=0, Mode=0, Dir=0, RUN → Pattern 01,02,04…80,01 with a step every 4 cycles; StepPulse single-cycle and coincident with each change; Dir=1 → 80,40… order reversed.
- Mode=1 free run for 16 steps → Pos 0,1…7,6…1,0,1; Pattern never repeats 80 or 01 back-to-back.
- Mode=2, Dir=0 then Dir=1 → 81,42,24,18,81 then 81,18,24,42; Mode=3 → FF,00 alternating.
- RunToggle pulse → Running=0, Pattern frozen for 100 cycles; three StepReq pulses → exactly three single-cycle steps, each 1 cycle after its pulse. StepReq and RunToggle rising in the same cycle → state toggles, no step.
- Mode switched 0→2 mid-period at Pos 5 → Pattern 81, Pos 0 the next cycle, no StepPulse; next step exactly 4 cycles later. Speed 3→0 with prescaler at 20 → step on the next cycle.
- ResetN asserted in the cycle of a scheduled step → Pattern 01, Pos 0, Running 1 immediately; RunToggle held high through reset release → no toggle.
